// File: rtl/ext_mem_latency_model_pkg.sv
// Shared types and helpers for the external DRAM latency model.
// Holds the FSM state type, the throttle LFSR taps and the byte-merge rule.
package ext_mem_model_pkg;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_WDATA = 1'b1
  } state_e;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [7:0] apply_mask(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ext_mem_latency_model_if.sv
// Request/write-data/response channels between riscv_top and the memory model.
interface ext_mem_latency_model_if #(
  parameter int DATA_BITS = 128,
  parameter int ADDR_BITS = 28,
  parameter int TAG_BITS  = 5
);
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_rw;
  logic [ADDR_BITS-1:0]   mem_req_addr;
  logic [TAG_BITS-1:0]    mem_req_tag;
  logic                   mem_req_data_valid;
  logic                   mem_req_data_ready;
  logic [DATA_BITS-1:0]   mem_req_data_bits;
  logic [DATA_BITS/8-1:0] mem_req_data_mask;
  logic                   mem_resp_valid;
  logic [TAG_BITS-1:0]    mem_resp_tag;
  logic [DATA_BITS-1:0]   mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready,
           mem_resp_valid, mem_resp_tag, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready,
           mem_resp_valid, mem_resp_tag, mem_resp_data
  );
endinterface

// File: rtl/ext_mem_latency_model_delay_line.sv
// Fixed-latency, never-stalling shift register carrying read responses.
// Payload stages only load on a valid beat so the last stage holds its value between responses.
module mem_model_delay_line #(
  parameter int W       = 8,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [LATENCY-1:0]        r_vld_pipe;
  logic [LATENCY-1:0][W-1:0] r_pay;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_pay      <= '0;
    end else begin
      r_vld_pipe[0] <= i_vld;
      if (i_vld) r_pay[0] <= i_data;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_pay[s] <= r_pay[s-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[LATENCY-1];
  assign o_data = r_pay[LATENCY-1];

endmodule

// File: rtl/ext_mem_latency_model.sv
// External DRAM model: req/wdata FSM, word RAM with byte masks, LFSR request throttle
// and a fixed-latency in-order read response pipe.
module ext_mem_latency_model
  import ext_mem_model_pkg::*;
#(
  parameter int          DATA_BITS    = 128,
  parameter int          ADDR_BITS    = 28,
  parameter int          TAG_BITS     = 5,
  parameter int          RAM_IDX_BITS = 16,
  parameter int          LATENCY      = 4,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input logic                    clk,
  input logic                    reset,
  ext_mem_latency_model_if.slave mem
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int PAY_W     = TAG_BITS + DATA_BITS;

  logic [DATA_BITS-1:0]    ram [0:(1<<RAM_IDX_BITS)-1];

  state_e                  r_state;
  logic [15:0]             r_lfsr;
  logic [RAM_IDX_BITS-1:0] r_widx;

  logic [RAM_IDX_BITS-1:0] w_idx;
  logic                    w_throttle;
  logic                    w_req_ready;
  logic                    w_data_ready;
  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic                    w_wd_acc;
  logic [DATA_BITS-1:0]    w_merged;
  logic [PAY_W-1:0]        w_resp_pay;
  logic                    w_unused;

  // Upper address bits alias onto the implemented words.
  assign w_idx    = mem.mem_req_addr[RAM_IDX_BITS-1:0];
  assign w_unused = ^mem.mem_req_addr;

  assign w_throttle   = STALL_EN && (r_lfsr[1:0] == 2'b00);
  assign w_req_ready  = reset && (r_state == S_REQ) && !w_throttle;
  assign w_data_ready = reset && (r_state == S_WDATA);

  assign w_rd_acc = w_req_ready && mem.mem_req_valid && !mem.mem_req_rw;
  assign w_wr_acc = w_req_ready && mem.mem_req_valid &&  mem.mem_req_rw;
  assign w_wd_acc = w_data_ready && mem.mem_req_data_valid;

  assign mem.mem_req_ready      = w_req_ready;
  assign mem.mem_req_data_ready = w_data_ready;

  for (genvar b = 0; b < MASK_BITS; b++) begin : g_lane
    assign w_merged[8*b +: 8] = apply_mask(ram[r_widx][8*b +: 8],
                                           mem.mem_req_data_bits[8*b +: 8],
                                           mem.mem_req_data_mask[b]);
  end

  // RAM contents survive reset; the harness preloads them hierarchically.
  always_ff @(posedge clk) begin
    if (w_wd_acc) ram[r_widx] <= w_merged;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_REQ;
      r_lfsr  <= SEED;
      r_widx  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      case (r_state)
        S_REQ: begin
          if (w_wr_acc) begin
            r_widx  <= w_idx;
            r_state <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_wd_acc) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Read data is captured at accept time, so it reflects every completed write.
  mem_model_delay_line #(
    .W       (PAY_W),
    .LATENCY (LATENCY)
  ) u_dly (
    .clk    (clk),
    .rst_n  (reset),
    .i_vld  (w_rd_acc),
    .i_data ({mem.mem_req_tag, ram[w_idx]}),
    .o_vld  (mem.mem_resp_valid),
    .o_data (w_resp_pay)
  );

  assign {mem.mem_resp_tag, mem.mem_resp_data} = w_resp_pay;

endmodule

// File: tb/tb_ext_mem_latency_model.sv
// Directed plus randomized bench for ext_mem_latency_model against a queue/array reference.
module tb_ext_mem_latency_model;

  localparam int LAT = 3;

  typedef struct {
    logic [4:0]   tag;
    logic [127:0] data;
    int           cyc;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_rw = 1'b0;
  logic [27:0]  req_addr = '0;
  logic [4:0]   req_tag = '0;
  logic         wd_valid = 1'b0;
  logic [127:0] wd_bits = '0;
  logic [15:0]  wd_mask = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls = 0;

  resp_t log_q[$];
  resp_t exp_q[$];
  resp_t mon_r;
  logic [127:0] mdl [16];

  ext_mem_latency_model_if #(.DATA_BITS(128), .ADDR_BITS(28), .TAG_BITS(5)) m0 ();
  ext_mem_latency_model_if #(.DATA_BITS(128), .ADDR_BITS(28), .TAG_BITS(5)) m1 ();

  assign m0.mem_req_valid      = req_valid & ~sel;
  assign m1.mem_req_valid      = req_valid & sel;
  assign m0.mem_req_data_valid = wd_valid & ~sel;
  assign m1.mem_req_data_valid = wd_valid & sel;
  assign m0.mem_req_rw = req_rw;        assign m1.mem_req_rw = req_rw;
  assign m0.mem_req_addr = req_addr;    assign m1.mem_req_addr = req_addr;
  assign m0.mem_req_tag = req_tag;      assign m1.mem_req_tag = req_tag;
  assign m0.mem_req_data_bits = wd_bits; assign m1.mem_req_data_bits = wd_bits;
  assign m0.mem_req_data_mask = wd_mask; assign m1.mem_req_data_mask = wd_mask;

  wire         w_ready  = sel ? m1.mem_req_ready      : m0.mem_req_ready;
  wire         w_dready = sel ? m1.mem_req_data_ready : m0.mem_req_data_ready;
  wire         w_rvalid = sel ? m1.mem_resp_valid     : m0.mem_resp_valid;
  wire [4:0]   w_rtag   = sel ? m1.mem_resp_tag       : m0.mem_resp_tag;
  wire [127:0] w_rdata  = sel ? m1.mem_resp_data      : m0.mem_resp_data;

  ext_mem_latency_model #(
    .DATA_BITS(128), .ADDR_BITS(28), .TAG_BITS(5), .RAM_IDX_BITS(4),
    .LATENCY(LAT), .STALL_EN(1'b0), .SEED(16'hACE1)
  ) dut0 (.clk(clk), .reset(rst_n), .mem(m0));

  ext_mem_latency_model #(
    .DATA_BITS(128), .ADDR_BITS(28), .TAG_BITS(5), .RAM_IDX_BITS(4),
    .LATENCY(LAT), .STALL_EN(1'b1), .SEED(16'hACE1)
  ) dut1 (.clk(clk), .reset(rst_n), .mem(m1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every response beat of the selected DUT, stamped with the cycle it was seen.
  always @(negedge clk) begin
    if (w_rvalid === 1'b1) begin
      mon_r.tag  = w_rtag;
      mon_r.data = w_rdata;
      mon_r.cyc  = cyc;
      log_q.push_back(mon_r);
    end
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_req(input logic rw, input logic [27:0] a, input logic [4:0] t, output int acc);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_tag = t;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (w_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      stalls++;
    end
    req_valid = 1'b0;
    if (acc < 0) chk("req_timeout", 128'(acc >= 0), 128'd1);
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    int acc;
    bit ok;
    do_req(1'b1, a, 5'd0, acc);
    wd_valid = 1'b1; wd_bits = d; wd_mask = m;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (w_dready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    wd_valid = 1'b0;
    if (!ok) chk("wdata_timeout", 128'(ok), 128'd1);
  endtask

  task automatic rd(input logic [27:0] a, input logic [4:0] t, input logic [127:0] expd);
    int acc;
    resp_t e;
    do_req(1'b0, a, t, acc);
    if (acc >= 0) begin
      e.tag = t; e.data = expd; e.cyc = acc + LAT - 1;
      exp_q.push_back(e);
    end
  endtask

  // Compares the observed response log with the expected list, then clears both.
  task automatic check_log(input string name);
    int n;
    repeat (LAT + 4) sync();
    chk({name, "_count"}, 128'(log_q.size()), 128'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_tag%0d", name, i),  128'(log_q[i].tag), 128'(exp_q[i].tag));
      chk($sformatf("%s_data%0d", name, i), log_q[i].data, exp_q[i].data);
      chk($sformatf("%s_cyc%0d", name, i),  128'(log_q[i].cyc), 128'(exp_q[i].cyc));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  logic [127:0] d1, e2, d6, d;
  logic [27:0]  a;
  logic [15:0]  m;
  int           acc;

  initial begin
    d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    e2 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
    d6 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;

    // Reset values
    repeat (3) sync();
    @(negedge clk);
    chk("rst_ready0",  128'(m0.mem_req_ready), 128'd0);
    chk("rst_dready0", 128'(m0.mem_req_data_ready), 128'd0);
    chk("rst_rvalid0", 128'(m0.mem_resp_valid), 128'd0);
    chk("rst_rtag0",   128'(m0.mem_resp_tag), 128'd0);
    chk("rst_rdata0",  m0.mem_resp_data, 128'd0);
    chk("rst_ready1",  128'(m1.mem_req_ready), 128'd0);
    chk("rst_rvalid1", 128'(m1.mem_resp_valid), 128'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready",  128'(w_ready), 128'd1);
    chk("idle_dready", 128'(w_dready), 128'd0);
    sync();
    log_q.delete();

    // Full-mask write then read, latency and hold
    wr(28'd5, d1, 16'hFFFF);
    rd(28'd5, 5'd7, d1);
    check_log("t1");
    @(negedge clk);
    chk("hold_valid", 128'(w_rvalid), 128'd0);
    chk("hold_tag",   128'(w_rtag), 128'd7);
    chk("hold_data",  w_rdata, d1);
    sync();

    // Partial byte mask
    wr(28'd9, '1, 16'hFFFF);
    wr(28'd9, '0, 16'h000F);
    rd(28'd9, 5'd8, e2);
    // Mask 0 leaves the word alone
    wr(28'd9, rnd128(), 16'h0000);
    rd(28'd9, 5'd9, e2);
    check_log("t2");

    // Aliasing with 4 index bits
    wr(28'h0000013, d6, 16'hFFFF);
    rd(28'h0000003, 5'd10, d6);
    rd(28'h0000013, 5'd11, d6);
    check_log("t6");

    // Back-to-back reads produce back-to-back responses
    rd(28'd5, 5'd1, d1);
    rd(28'd9, 5'd2, e2);
    rd(28'd3, 5'd3, d6);
    rd(28'd5, 5'd4, d1);
    check_log("t3");

    // Reset with two reads in flight
    do_req(1'b0, 28'd5, 5'd12, acc);
    do_req(1'b0, 28'd9, 5'd13, acc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rr_ready", 128'(w_ready), 128'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_rvalid", 128'(w_rvalid), 128'd0);
    chk("rr_rtag",   128'(w_rtag), 128'd0);
    chk("rr_rdata",  w_rdata, 128'd0);
    sync();
    check_log("t5_stale");
    rd(28'd5, 5'd14, d1);
    check_log("t5_keep");

    // Reset during the write-data phase drops the write
    do_req(1'b1, 28'd5, 5'd0, acc);
    wd_valid = 1'b1; wd_bits = rnd128(); wd_mask = 16'hFFFF;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_dready", 128'(w_dready), 128'd0);
    sync();
    rst_n = 1'b1;
    wd_valid = 1'b0;
    rd(28'd5, 5'd15, d1);
    check_log("t5w");

    // Random traffic with throttling against an array model
    sel = 1'b1;
    sync();
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      d = rnd128();
      a = {24'($urandom()), 4'(i)};
      wr(a, d, 16'hFFFF);
      mdl[i] = d;
    end
    for (int i = 0; i < 200; i++) begin
      a = 28'($urandom());
      if ($urandom_range(1, 0) == 1) begin
        d = rnd128();
        m = 16'($urandom());
        wr(a, d, m);
        for (int b = 0; b < 16; b++)
          if (m[b]) mdl[a % 16][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd(a, 5'($urandom()), mdl[a % 16]);
      end
      if ($urandom_range(3, 0) == 0) sync();
    end
    check_log("t4");
    chk("t4_stalled", 128'(stalls > 0), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
